// File: rtl/speed_actuator_if.sv
// speed_actuator_if: command and status bundle between the cruise FSM side and the drive stage
interface speed_actuator_if;
    logic       enable;
    logic       accelerate_car;
    logic       unlock_doors;
    logic [7:0] car_speed;
    logic       doors_unlocked;
    logic       moving;
    logic [1:0] state;

    modport master (
        output enable, accelerate_car, unlock_doors,
        input  car_speed, doors_unlocked, moving, state
    );

    modport slave (
        input  enable, accelerate_car, unlock_doors,
        output car_speed, doors_unlocked, moving, state
    );
endinterface

// File: rtl/speed_actuator.sv
// speed_actuator: ramps vehicle speed on a prescaled tick and gates the door release
module speed_actuator #(
    parameter logic [7:0] ACCEL_STEP = 8'd10,
    parameter logic [7:0] DECEL_STEP = 8'd2,
    parameter logic [7:0] MAX_SPEED  = 8'd200,
    parameter int         TICK_DIV   = 4,
    parameter int         DOOR_DELAY = 3
) (
    input logic             clk,
    input logic             rst,
    speed_actuator_if.slave bus
);
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int DW = $clog2(DOOR_DELAY + 1);

    typedef enum logic [1:0] {STOPPED = 2'b00, ACCEL = 2'b01, DECEL = 2'b10} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [7:0]    speed_q, speed_d;
    logic [DW-1:0] door_q, door_d;
    logic          doors_q, doors_d;
    logic          tick;
    logic [8:0]    sum;
    logic          acc;

    assign acc  = bus.accelerate_car;
    assign tick = bus.enable && pre_q == PW'(TICK_DIV - 1);
    assign sum  = {1'b0, speed_q} + {1'b0, ACCEL_STEP};

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= STOPPED;
        else      state_q <= state_d;
    end

    // next state; a decel tick that reaches zero stops on the same edge
    always_comb begin
        state_d = state_q;
        if (bus.enable)
            case (state_q)
                STOPPED: state_d = acc ? ACCEL : STOPPED;
                ACCEL:   state_d = acc ? ACCEL : DECEL;
                DECEL:   state_d = acc ? ACCEL :
                                   (speed_q == 8'd0 || (tick && speed_q <= DECEL_STEP)) ? STOPPED : DECEL;
                default: state_d = STOPPED;
            endcase
    end

    // datapath next values; speed uses the pre-edge state, door release uses the post-edge counter
    always_comb begin
        pre_d   = !bus.enable ? pre_q : tick ? '0 : pre_q + PW'(1);
        speed_d = !tick ? speed_q :
                  state_q == ACCEL ? (sum > {1'b0, MAX_SPEED} ? MAX_SPEED : sum[7:0]) :
                  state_q == DECEL ? (speed_q <= DECEL_STEP ? 8'd0 : speed_q - DECEL_STEP) : 8'd0;
        door_d  = !bus.enable ? door_q :
                  state_d != STOPPED ? '0 :
                  (tick && state_q == STOPPED && door_q != DW'(DOOR_DELAY)) ? door_q + DW'(1) : door_q;
        doors_d = (!bus.unlock_doors || acc) ? 1'b0 :
                  bus.enable ? (state_d == STOPPED && door_d == DW'(DOOR_DELAY)) : doors_q;
    end

    // datapath registers; door clears still land while frozen
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q   <= '0;
            speed_q <= 8'd0;
            door_q  <= '0;
            doors_q <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            speed_q <= speed_d;
            door_q  <= door_d;
            doors_q <= doors_d;
        end
    end

    assign bus.car_speed      = speed_q;
    assign bus.doors_unlocked = doors_q;
    assign bus.moving         = speed_q != 8'd0;
    assign bus.state          = state_q;
endmodule

// File: tb/tb_speed_actuator.sv
// tb_speed_actuator: directed ramp, saturation, floor, door, freeze and reversal checks
module tb_speed_actuator;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   fails = 0;

    typedef struct {
        string      tag;
        logic [7:0] spd;
        logic [1:0] st;
        logic       dr;
    } exp_t;

    exp_t q[$];

    speed_actuator_if bus ();

    speed_actuator dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_next();
        exp_t e;
        e = q.pop_front();
        checks++;
        assert (bus.car_speed === e.spd) else begin
            fails++;
            $error("FAIL %s speed got %0d expected %0d", e.tag, bus.car_speed, e.spd);
        end
        checks++;
        assert (bus.state === e.st) else begin
            fails++;
            $error("FAIL %s state got %0d expected %0d", e.tag, bus.state, e.st);
        end
        checks++;
        assert (bus.doors_unlocked === e.dr) else begin
            fails++;
            $error("FAIL %s doors got %0d expected %0d", e.tag, bus.doors_unlocked, e.dr);
        end
        checks++;
        assert (bus.moving === (e.spd != 8'd0)) else begin
            fails++;
            $error("FAIL %s moving got %0d expected %0d", e.tag, bus.moving, e.spd != 8'd0);
        end
    endtask

    task automatic step(input int n, input string tag, input int spd, input int st, input int dr);
        exp_t e;
        e.tag = tag;
        e.spd = 8'(spd);
        e.st  = 2'(st);
        e.dr  = dr[0];
        q.push_back(e);
        if (n > 0) run(n);
        check_next();
    endtask

    initial begin
        bus.enable = 1'b1;
        bus.accelerate_car = 1'b0;
        bus.unlock_doors = 1'b1;
        run(2);
        step(0, "reset", 0, 0, 0);
        rst = 1'b1;
        step(11, "door_wait", 0, 0, 0);
        step(1, "door_release", 0, 0, 1);
        bus.enable = 1'b0;
        step(1, "door_hold_frozen", 0, 0, 1);
        bus.unlock_doors = 1'b0;
        step(1, "door_clear_frozen", 0, 0, 0);
        bus.unlock_doors = 1'b1;
        bus.enable = 1'b1;
        step(1, "door_rerelease", 0, 0, 1);
        bus.accelerate_car = 1'b1;
        step(1, "override", 0, 1, 0);
        step(1, "pre_tick", 0, 1, 0);
        step(1, "first_tick", 10, 1, 0);
        for (int k = 2; k <= 6; k++) step(4, "ramp60", 10 * k, 1, 0);
        bus.unlock_doors = 1'b0;
        rst = 1'b0;
        #1;
        step(0, "reset_mid_ramp", 0, 0, 0);
        #1 rst = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            step(3, "sat_before", (10 * (k - 1) > 200) ? 200 : 10 * (k - 1), 1, 0);
            step(1, "sat_tick", (10 * k > 200) ? 200 : 10 * k, 1, 0);
        end
        bus.accelerate_car = 1'b0;
        step(1, "decel_enter", 200, 2, 0);
        step(3, "decel_first", 198, 2, 0);
        step(4 * 79, "decel_to_40", 40, 2, 0);
        bus.accelerate_car = 1'b1;
        step(1, "reverse_state", 40, 1, 0);
        step(2, "reverse_hold", 40, 1, 0);
        step(1, "reverse_tick", 50, 1, 0);
        bus.accelerate_car = 1'b0;
        step(1, "decel2_enter", 50, 2, 0);
        step(95, "floor_2", 2, 2, 0);
        step(4, "floor_0", 0, 0, 0);
        step(4, "floor_stay", 0, 0, 0);
        bus.accelerate_car = 1'b1;
        step(12, "reach_30", 30, 1, 0);
        step(2, "phase_2", 30, 1, 0);
        bus.enable = 1'b0;
        step(10, "frozen", 30, 1, 0);
        bus.enable = 1'b1;
        step(1, "resume_phase3", 30, 1, 0);
        step(1, "resume_tick", 40, 1, 0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
